// File: rtl/instr_fetch_stage.sv
// Fetch stage: loader-filled instruction memory, registered fetch with stall/flush, sticky halt.
// Optional simulation trace when FETCH_TRACE_EN is defined (no logic change).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset; waiting for the first loader write
// LOAD  | loader streaming words; first idle strobe releases to RUN
// RUN   | fetching mem[pc] each edge; ready asserted
// HALT  | HALT_WORD retired; outputs frozen until reset
module instr_fetch_stage #(
    parameter int                   PC_W      = 7,
    parameter int                   INSTR_W   = 9,
    parameter logic [INSTR_W-1:0]   HALT_WORD = 9'h1FF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load_en,
    input  logic [PC_W-1:0]    i_load_addr,
    input  logic [INSTR_W-1:0] i_load_data,
    input  logic [PC_W-1:0]    i_pc,
    input  logic               i_stall,
    input  logic               i_flush,
    output logic               o_ready,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_instr_pc,
    output logic               o_instr_valid,
    output logic               o_done
);

    localparam int DEPTH = 1 << PC_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_instr_pc;
    logic               r_instr_valid;
    logic               r_done;
    logic [INSTR_W-1:0] r_mem [DEPTH];

    logic               w_mem_we;
    logic [INSTR_W-1:0] w_rd_data;
    logic               w_halt_hit;

    // Writes are confined to IDLE/LOAD, so a fetch never races a write.
    assign w_mem_we   = i_load_en && ((r_state == S_IDLE) || (r_state == S_LOAD));
    assign w_rd_data  = r_mem[i_pc];
    assign w_halt_hit = r_instr_valid && (r_instr == HALT_WORD) && !i_stall;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[i_load_addr] <= i_load_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_ready       <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_load_en) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!i_load_en) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Halt takes priority over a same-cycle flush.
                    if (w_halt_hit) begin
                        r_state       <= S_HALT;
                        r_ready       <= 1'b0;
                        r_instr_valid <= 1'b0;
                        r_done        <= 1'b1;
                    end else if (i_flush) begin
                        r_instr       <= w_rd_data;
                        r_instr_pc    <= i_pc;
                        r_instr_valid <= 1'b0;
                    end else if (!i_stall) begin
                        r_instr       <= w_rd_data;
                        r_instr_pc    <= i_pc;
                        r_instr_valid <= 1'b1;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready       = r_ready;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
    assign o_done        = r_done;

`ifdef FETCH_TRACE_EN
    always @(posedge i_clk) begin
        if (!i_reset && (r_state == S_RUN) && !i_stall) begin
            $display("Fetch: PC = %h, Instr = %h, Valid = %b, Flush = %b",
                     i_pc, w_rd_data, !i_flush, i_flush);
            if (w_halt_hit) begin
                $display("Halt at PC = %h", r_instr_pc);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: directed scenarios plus randomized runs
// against a behavioural model; a monitor compares every queued expectation.
module tb_instr_fetch_stage;

    localparam int          PC_W    = 7;
    localparam int          INSTR_W = 9;
    localparam int          DEPTH   = 1 << PC_W;
    localparam logic [8:0]  HALT    = 9'h1FF;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_HALT = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               load_en;
    logic [PC_W-1:0]    load_addr;
    logic [INSTR_W-1:0] load_data;
    logic [PC_W-1:0]    pc;
    logic               stall;
    logic               flush;
    logic               ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               done;

    instr_fetch_stage dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_load_en     (load_en),
        .i_load_addr   (load_addr),
        .i_load_data   (load_data),
        .i_pc          (pc),
        .i_stall       (stall),
        .i_flush       (flush),
        .o_ready       (ready),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_instr_valid (instr_valid),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               ready;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    ipc;
        logic               valid;
        logic               done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: architectural view of the stage, memory survives reset.
    int                 m_mode;
    logic [INSTR_W-1:0] m_mem [DEPTH];
    logic               m_ready;
    logic [INSTR_W-1:0] m_instr;
    logic [PC_W-1:0]    m_ipc;
    logic               m_valid;
    logic               m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_ready = 1'b0;
        m_instr = '0;
        m_ipc   = '0;
        m_valid = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic model_step(input logic le, input logic [PC_W-1:0] la,
                              input logic [INSTR_W-1:0] ld, input logic [PC_W-1:0] p,
                              input logic st, input logic fl);
        if (m_mode == M_IDLE) begin
            if (le) begin
                m_mem[la] = ld;
                m_mode    = M_LOAD;
            end
        end else if (m_mode == M_LOAD) begin
            if (le) m_mem[la] = ld;
            else    m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (m_valid && m_instr == HALT && !st) begin
                m_mode  = M_HALT;
                m_done  = 1'b1;
                m_valid = 1'b0;
            end else if (fl || !st) begin
                m_instr = m_mem[p];
                m_ipc   = p;
                m_valid = !fl;
            end
        end
        m_ready = (m_mode == M_RUN);
    endtask

    // One clock of stimulus: drive at negedge, expectation applies after the next posedge.
    task automatic cycle(input logic le, input logic [PC_W-1:0] la,
                         input logic [INSTR_W-1:0] ld, input logic [PC_W-1:0] p,
                         input logic st, input logic fl);
        exp_t e;
        @(negedge clk);
        load_en   = le;
        load_addr = la;
        load_data = ld;
        pc        = p;
        stall     = st;
        flush     = fl;
        model_step(le, la, ld, p, st, fl);
        e.ready = m_ready;
        e.instr = m_instr;
        e.ipc   = m_ipc;
        e.valid = m_valid;
        e.done  = m_done;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        pc        = '0;
        stall     = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_instr"}, 32'(instr), 32'd0);
        chk({tag, "_instr_pc"}, 32'(instr_pc), 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge can act.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b1;
        idle_inputs();
        #1;
        check_reset_outputs(tag);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_random(input int halt_one_in);
        for (int a = 0; a < DEPTH; a++) begin
            logic [INSTR_W-1:0] d;
            d = INSTR_W'($urandom_range(0, 32'h1FE));
            if (halt_one_in > 0 && $urandom_range(0, halt_one_in - 1) == 0) d = HALT;
            cycle(1'b1, PC_W'(a), d, PC_W'($urandom), 1'b0, 1'b0);
        end
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle($urandom_range(0, 3) == 0, PC_W'($urandom), INSTR_W'($urandom),
                  PC_W'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ready", 32'(ready), 32'(e.ready));
            chk("instr", 32'(instr), 32'(e.instr));
            chk("instr_pc", 32'(instr_pc), 32'(e.ipc));
            chk("instr_valid", 32'(instr_valid), 32'(e.valid));
            chk("done", 32'(done), 32'(e.done));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // Reset in the middle of a load; mem[3] must survive it.
        cycle(1'b1, 7'd3, 9'h033, '0, 1'b0, 1'b0);
        cycle(1'b1, 7'd4, 9'h044, '0, 1'b0, 1'b0);
        async_reset("rst_mid_load");

        cycle(1'b1, 7'd0, 9'h010, '0, 1'b0, 1'b0);
        cycle(1'b1, 7'd1, 9'h021, '0, 1'b0, 1'b0);
        cycle(1'b1, 7'd2, HALT,   '0, 1'b0, 1'b0);
        cycle(1'b1, 7'd5, 9'h055, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 7'd0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, '0, '0, 7'd1, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 7'd1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 7'd1, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 7'd5, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 7'd0, 1'b1, 1'b1);
        cycle(1'b0, '0, '0, 7'd3, 1'b0, 1'b0);
        cycle(1'b1, 7'd0, 9'h0AA, 7'd0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 7'd0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 7'd2, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 7'd1, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 7'd0, 1'b0, 1'b1);
        cycle(1'b1, 7'd1, 9'h0BB, 7'd5, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 7'd1, 1'b0, 1'b1);
        async_reset("rst_in_halt");

        // Randomized run over a fully loaded memory, then reset while live.
        load_random(0);
        random_run(300);
        async_reset("rst_mid_run");

        // Reload with sparse halt words and run until the model halts.
        load_random(16);
        for (int i = 0; i < 400 && !m_done; i++) random_run(1);
        random_run(10);

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
